// File: rtl/div3_pkg.sv
// -----------------------------------------------------------------------------
// div3_pkg
// Shared types and widths for the divisible-by-3 sweep controller and its
// hit FIFO.
//   NUM_W         : width of a swept value / checker operand
//   COUNT_W       : width of the hit counter (covers a full 0..65535 sweep)
//   sweep_state_t : sweep controller FSM states
// -----------------------------------------------------------------------------
package div3_pkg;

    localparam int NUM_W   = 16;
    localparam int COUNT_W = 17;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        ARM,
        WAIT,
        RECORD,
        FINISH
    } sweep_state_t;

endpackage : div3_pkg

// File: rtl/div3_hit_fifo.sv
// -----------------------------------------------------------------------------
// div3_hit_fifo
// Synchronous FIFO holding the values that the checker flagged as divisible.
// Ports:
//   clk, reset       : clock, synchronous active-high reset (empties FIFO)
//   push, push_data  : write request and value; dropped when full unless a
//                      pop happens in the same cycle
//   pop              : remove head; ignored when empty
//   full, empty      : occupancy flags
//   head             : value at the head, 0 while empty
// -----------------------------------------------------------------------------
module div3_hit_fifo
    import div3_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [NUM_W-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [NUM_W-1:0] head
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [NUM_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == (PTR_W+1)'(DEPTH));

    // A pop frees the slot the simultaneous push needs, so a full FIFO
    // still accepts a push when it is also being popped.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign head = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + (PTR_W+1)'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - (PTR_W+1)'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; the pointers and
    // count define validity, and head is forced to 0 while empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule : div3_hit_fifo

// File: rtl/div3_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// div3_sweep_ctrl
// Drives an external divisible-by-3 checker over every value in [lo, hi],
// counts the hits and queues the hit values in a FIFO for downstream logic.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   go, lo, hi            : start a sweep over [lo, hi] (accepted only in IDLE)
//   busy, done            : sweep in progress / one-cycle end-of-sweep pulse
//   hit_count             : hits found in the current/last sweep
//   overflow, timeout_err : sticky error flags, cleared by an accepted go
//   hit_valid, hit_data,
//   hit_pop               : hit FIFO head interface
//   chk_number, chk_reset : operand and reset towards the checker
//   chk_out, chk_start    : checker verdict and running flag
// -----------------------------------------------------------------------------
module div3_sweep_ctrl
    import div3_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int WAIT_MAX   = 22000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               go,
    input  logic [NUM_W-1:0]   lo,
    input  logic [NUM_W-1:0]   hi,
    output logic               busy,
    output logic               done,
    output logic [COUNT_W-1:0] hit_count,
    output logic               overflow,
    output logic               timeout_err,
    output logic               hit_valid,
    output logic [NUM_W-1:0]   hit_data,
    input  logic               hit_pop,
    output logic [NUM_W-1:0]   chk_number,
    output logic               chk_reset,
    input  logic               chk_out,
    input  logic               chk_start
);

    localparam int WAIT_W = $clog2(WAIT_MAX + 1);

    sweep_state_t       state_q, state_d;
    logic [NUM_W-1:0]   cur_q, cur_d;
    logic [NUM_W-1:0]   hi_q, hi_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic               verdict_q, verdict_d;
    logic [COUNT_W-1:0] hit_count_q, hit_count_d;
    logic               overflow_q, overflow_d;
    logic               timeout_q, timeout_d;
    logic [NUM_W-1:0]   chk_number_q, chk_number_d;
    logic               push_req;
    logic               fifo_full;
    logic               fifo_empty;

    always_comb begin
        state_d      = state_q;
        cur_d        = cur_q;
        hi_d         = hi_q;
        wait_cnt_d   = wait_cnt_q;
        verdict_d    = verdict_q;
        hit_count_d  = hit_count_q;
        overflow_d   = overflow_q;
        timeout_d    = timeout_q;
        chk_number_d = chk_number_q;
        push_req     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (go) begin
                    hi_d        = hi;
                    cur_d       = lo;
                    hit_count_d = '0;
                    overflow_d  = 1'b0;
                    timeout_d   = 1'b0;
                    if (lo > hi) begin
                        state_d = FINISH;
                    end else begin
                        chk_number_d = lo;
                        state_d      = LAUNCH;
                    end
                end
            end

            LAUNCH: begin
                wait_cnt_d = '0;
                state_d    = ARM;
            end

            // The checker's start flag is registered, so it is only
            // trustworthy one cycle after its reset is released.
            ARM: begin
                state_d = WAIT;
            end

            WAIT: begin
                wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                if (!chk_start) begin
                    verdict_d = chk_out;
                    state_d   = RECORD;
                end else if (wait_cnt_d == WAIT_W'(WAIT_MAX)) begin
                    timeout_d = 1'b1;
                    verdict_d = 1'b0;
                    state_d   = RECORD;
                end
            end

            RECORD: begin
                if (verdict_q) begin
                    hit_count_d = hit_count_q + COUNT_W'(1);
                    push_req    = 1'b1;
                    // The FIFO accepts a push into a full queue only when
                    // the head is popped in the same cycle.
                    if (fifo_full && !hit_pop) begin
                        overflow_d = 1'b1;
                    end
                end
                // Compare before incrementing so hi = 65535 never wraps cur.
                if (cur_q == hi_q) begin
                    state_d = FINISH;
                end else begin
                    cur_d        = cur_q + NUM_W'(1);
                    chk_number_d = cur_d;
                    state_d      = LAUNCH;
                end
            end

            FINISH: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cur_q        <= '0;
            hi_q         <= '0;
            wait_cnt_q   <= '0;
            verdict_q    <= 1'b0;
            hit_count_q  <= '0;
            overflow_q   <= 1'b0;
            timeout_q    <= 1'b0;
            chk_number_q <= '0;
        end else begin
            state_q      <= state_d;
            cur_q        <= cur_d;
            hi_q         <= hi_d;
            wait_cnt_q   <= wait_cnt_d;
            verdict_q    <= verdict_d;
            hit_count_q  <= hit_count_d;
            overflow_q   <= overflow_d;
            timeout_q    <= timeout_d;
            chk_number_q <= chk_number_d;
        end
    end

    div3_hit_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_hit_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_req),
        .push_data (cur_q),
        .pop       (hit_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (hit_data)
    );

    assign busy        = (state_q == LAUNCH) || (state_q == ARM) ||
                         (state_q == WAIT)   || (state_q == RECORD);
    assign done        = (state_q == FINISH);
    assign hit_count   = hit_count_q;
    assign overflow    = overflow_q;
    assign timeout_err = timeout_q;
    assign hit_valid   = !fifo_empty;
    assign chk_number  = chk_number_q;
    // The checker is held in reset with this block and pulsed once per value.
    assign chk_reset   = reset || (state_q == LAUNCH);

endmodule : div3_sweep_ctrl
